// File: rtl/l2_splice_loader.sv
// Byte-stream frame loader feeding the 96-bit L2 register splice: sync hunt, payload steering, checksum gate.
// Optional idle timeout inside a frame is enabled by defining L2_LOADER_TIMEOUT_EN.
module l2_splice_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int          NUM_BYTES      = 12,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [7:0] din,
    output logic [3:0] Sel,
    output logic       We,
    output logic       Zero,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {HUNT, LOAD, CSUM, RESULT} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

    generate
        if (NUM_BYTES < 1 || NUM_BYTES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("l2_splice_loader: parameter out of range");
        end
    endgenerate

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic [7:0] sum_reg, sum_next;
    logic [7:0] din_reg, din_next;
    logic [3:0] sel_reg, sel_next;
    logic       we_reg, we_next;
    logic       zero_reg, zero_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic       accept;
    logic [7:0] running_sum;

`ifdef L2_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_reg, idle_cnt_next;
`endif

    // Only the RESULT cycle refuses input, so ready never looks at valid.
    assign byte_ready  = (state_reg != RESULT);
    assign busy        = (state_reg != HUNT);
    assign accept      = byte_valid & byte_ready;
    assign running_sum = sum_reg + byte_in;

    assign din        = din_reg;
    assign Sel        = sel_reg;
    assign We         = we_reg;
    assign Zero       = zero_reg;
    assign frame_done = done_reg;
    assign frame_err  = err_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        sum_next   = sum_reg;
        din_next   = din_reg;
        sel_next   = sel_reg;
        we_next    = 1'b0;
        zero_next  = zero_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            HUNT: begin
                if (accept && byte_in == SYNC_BYTE) begin
                    state_next = LOAD;
                    idx_next   = 4'd0;
                    sum_next   = 8'd0;
                end
            end
            LOAD: begin
                if (accept) begin
                    din_next = byte_in;
                    sel_next = idx_reg;
                    we_next  = 1'b1;
                    sum_next = running_sum;
                    // Blank the splice as soon as it starts holding a mix of old and new bytes.
                    if (idx_reg == 4'd0) begin
                        zero_next = 1'b1;
                    end
                    if (idx_reg == LAST_IDX) begin
                        state_next = CSUM;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = RESULT;
                    if (running_sum == 8'd0) begin
                        done_next = 1'b1;
                        zero_next = 1'b0;
                    end else begin
                        err_next  = 1'b1;
                        zero_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase

`ifdef L2_LOADER_TIMEOUT_EN
        idle_cnt_next = '0;
        if ((state_reg == LOAD || state_reg == CSUM) && !accept) begin
            if (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next = HUNT;
                err_next   = 1'b1;
                zero_next  = 1'b1;
            end else begin
                idle_cnt_next = idle_cnt_reg + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= HUNT;
            idx_reg   <= 4'd0;
            sum_reg   <= 8'd0;
            din_reg   <= 8'd0;
            sel_reg   <= 4'd0;
            we_reg    <= 1'b0;
            zero_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
`ifdef L2_LOADER_TIMEOUT_EN
            idle_cnt_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            sum_reg   <= sum_next;
            din_reg   <= din_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
            zero_reg  <= zero_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
`ifdef L2_LOADER_TIMEOUT_EN
            idle_cnt_reg <= idle_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_l2_splice_loader.sv
// Randomized bench for l2_splice_loader: a splice/write-log monitor plus frame-level reference arithmetic.
module tb_l2_splice_loader;
    localparam int NB = 12;
`ifdef L2_LOADER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [7:0] din;
    logic [3:0] Sel;
    logic       We;
    logic       Zero;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    l2_splice_loader #(.SYNC_BYTE(8'hA5), .NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .din(din), .Sel(Sel), .We(We), .Zero(Zero),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: models the splice register file and logs every write strobe.
    logic [11:0] wlog[$];
    logic [7:0]  splice [16];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          zero_glitch = 0;
    logic        prev_zero = 1'b1;
    always @(negedge clk) begin
        if (We === 1'b1) begin
            wlog.push_back({Sel, din});
            splice[Sel] = din;
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (prev_zero === 1'b1 && Zero === 1'b0 && frame_done !== 1'b1) zero_glitch++;
        prev_zero = Zero;
    end

    logic [7:0] pay [NB];

    function automatic logic [95:0] splice_vec();
        logic [95:0] v = '0;
        for (int i = 0; i < NB; i++) v[i*8 +: 8] = splice[i];
        return v;
    endfunction

    function automatic logic [95:0] pay_vec();
        logic [95:0] v = '0;
        for (int i = 0; i < NB; i++) v[i*8 +: 8] = pay[i];
        return v;
    endfunction

    function automatic int pay_sum();
        int s = 0;
        for (int i = 0; i < NB; i++) s += int'(pay[i]);
        return s;
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic put_byte(input logic [7:0] b);
        int g = 0;
        while (byte_ready !== 1'b1 && g < 8) begin
            byte_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        byte_in = b;
        byte_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input int gap_pct);
        put_byte(8'hA5);
        for (int i = 0; i < NB; i++) begin
            if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            put_byte(pay[i]);
        end
        if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
        put_byte(c);
    endtask

    task automatic test_reset();
        int bw, bd, be;
        rst = 1'b1;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", byte_ready); end
        total++; if (Zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", Zero); end
        total++; if ({We, busy, frame_done, frame_err} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {We, busy, frame_done, frame_err}); end
        total++; if ({Sel, din} !== 12'h000) begin bad++; $display("FAIL reset_sel_din: got %h want 000", {Sel, din}); end
        bw = wlog.size(); bd = done_cnt; be = err_cnt;
        idle(100);
        total++; if (wlog.size() - bw + done_cnt - bd + err_cnt - be != 0) begin bad++; $display("FAIL idle_activity: got %0d events want 0", wlog.size() - bw + done_cnt - bd + err_cnt - be); end
        total++; if ({Zero, byte_ready, busy} !== 3'b110) begin bad++; $display("FAIL idle_state: got %b want 110", {Zero, byte_ready, busy}); end
    endtask

    task automatic test_good_frame();
        int bw, bd, be;
        bw = wlog.size(); bd = done_cnt; be = err_cnt;
        for (int i = 0; i < NB; i++) pay[i] = 8'(i + 1);
        put_byte(8'hA5);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy: got %b want 1", busy); end
        for (int i = 0; i < NB; i++) put_byte(pay[i]);
        put_byte(8'hB2);
        total++; if ({byte_ready, frame_done, frame_err, Zero} !== 4'b0100) begin bad++; $display("FAIL good_result: ready/done/err/zero got %b want 0100", {byte_ready, frame_done, frame_err, Zero}); end
        idle(2);
        total++; if (wlog.size() - bw != NB) begin bad++; $display("FAIL good_wcount: got %0d want %0d", wlog.size() - bw, NB); end
        for (int i = 0; i < NB && bw + i < wlog.size(); i++) begin
            total++; if (wlog[bw + i] !== {4'(i), pay[i]}) begin bad++; $display("FAIL good_write%0d: got %h want %h", i, wlog[bw + i], {4'(i), pay[i]}); end
        end
        total++; if (splice_vec() !== 96'h0C0B0A090807060504030201) begin bad++; $display("FAIL good_splice: got %h want 0c0b0a090807060504030201", splice_vec()); end
        total++; if (done_cnt - bd != 1 || err_cnt - be != 0) begin bad++; $display("FAIL good_pulses: done %0d err %0d want 1 0", done_cnt - bd, err_cnt - be); end
        total++; if ({Zero, busy} !== 2'b00) begin bad++; $display("FAIL good_after: zero/busy got %b want 00", {Zero, busy}); end
    endtask

    task automatic test_bad_csum();
        int bw, bd, be;
        bw = wlog.size(); bd = done_cnt; be = err_cnt;
        for (int i = 0; i < NB; i++) pay[i] = 8'(i + 1);
        put_byte(8'hA5);
        put_byte(pay[0]);
        total++; if ({We, Sel, din, Zero} !== {1'b1, 4'd0, 8'h01, 1'b1}) begin bad++; $display("FAIL bad_first_write: got %h want %h", {We, Sel, din, Zero}, {1'b1, 4'd0, 8'h01, 1'b1}); end
        for (int i = 1; i < NB; i++) put_byte(pay[i]);
        put_byte(8'hB3);
        total++; if ({frame_done, frame_err, Zero} !== 3'b011) begin bad++; $display("FAIL bad_result: done/err/zero got %b want 011", {frame_done, frame_err, Zero}); end
        idle(2);
        total++; if (wlog.size() - bw != NB) begin bad++; $display("FAIL bad_wcount: got %0d want %0d", wlog.size() - bw, NB); end
        total++; if (done_cnt - bd != 0 || err_cnt - be != 1) begin bad++; $display("FAIL bad_pulses: done %0d err %0d want 0 1", done_cnt - bd, err_cnt - be); end
    endtask

    task automatic test_random_frames(input int nframes);
        int bw, bd, be, s, ng;
        logic [7:0] c, g;
        logic exp_pass;
        for (int f = 0; f < nframes; f++) begin
            bw = wlog.size(); bd = done_cnt; be = err_cnt;
            if (f == 0) begin
                put_byte(8'h00); put_byte(8'hFF); put_byte(8'h5A);
            end else begin
                ng = $urandom_range(0, 3);
                for (int k = 0; k < ng; k++) begin
                    g = 8'($urandom);
                    put_byte(g == 8'hA5 ? 8'h5A : g);
                end
            end
            for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
            s = pay_sum();
            c = 8'((256 - (s % 256)) % 256);
            if ($urandom_range(0, 1) == 0) c = c + 8'($urandom_range(1, 255));
            exp_pass = ((s + int'(c)) % 256) == 0;
            send_frame(c, 30);
            idle(2);
            total++; if (wlog.size() - bw != NB) begin bad++; $display("FAIL rnd%0d_wcount: got %0d want %0d", f, wlog.size() - bw, NB); end
            for (int i = 0; i < NB && bw + i < wlog.size(); i++) begin
                total++; if (wlog[bw + i] !== {4'(i), pay[i]}) begin bad++; $display("FAIL rnd%0d_write%0d: got %h want %h", f, i, wlog[bw + i], {4'(i), pay[i]}); end
            end
            total++; if (done_cnt - bd != int'(exp_pass) || err_cnt - be != int'(!exp_pass)) begin bad++; $display("FAIL rnd%0d_pulses: done %0d err %0d pass %b", f, done_cnt - bd, err_cnt - be, exp_pass); end
            total++; if (Zero !== !exp_pass) begin bad++; $display("FAIL rnd%0d_zero: got %b want %b", f, Zero, !exp_pass); end
            if (exp_pass) begin
                total++; if (splice_vec() !== pay_vec()) begin bad++; $display("FAIL rnd%0d_splice: got %h want %h", f, splice_vec(), pay_vec()); end
            end
        end
        total++; if (zero_glitch != 0) begin bad++; $display("FAIL zero_without_done: got %0d want 0", zero_glitch); end
    endtask

    task automatic test_back_to_back();
        int t0, bd;
        bd = done_cnt;
        for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
        t0 = cyc;
        send_frame(8'((256 - (pay_sum() % 256)) % 256), 0);
        send_frame(8'((256 - (pay_sum() % 256)) % 256), 0);
        total++; if (cyc - t0 != 2 * (NB + 2) + 1) begin bad++; $display("FAIL b2b_cycles: got %0d want %0d", cyc - t0, 2 * (NB + 2) + 1); end
        idle(2);
        total++; if (done_cnt - bd != 2) begin bad++; $display("FAIL b2b_done: got %0d want 2", done_cnt - bd); end
    endtask

    task automatic test_reset_midframe();
        int bw, bd;
        for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
        send_frame(8'((256 - (pay_sum() % 256)) % 256), 0);
        idle(1);
        put_byte(8'hA5);
        for (int i = 0; i < 5; i++) put_byte(pay[i]);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({byte_ready, Zero, We, busy, frame_done, frame_err} !== 6'b110000) begin bad++; $display("FAIL mid_reset_flags: got %b want 110000", {byte_ready, Zero, We, busy, frame_done, frame_err}); end
        total++; if ({Sel, din} !== 12'h000) begin bad++; $display("FAIL mid_reset_sel_din: got %h want 000", {Sel, din}); end
        @(negedge clk);
        bw = wlog.size(); bd = done_cnt;
        for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
        send_frame(8'((256 - (pay_sum() % 256)) % 256), 20);
        idle(2);
        total++; if (wlog.size() - bw != NB) begin bad++; $display("FAIL mid_wcount: got %0d want %0d", wlog.size() - bw, NB); end
        for (int i = 0; i < NB && bw + i < wlog.size(); i++) begin
            total++; if (wlog[bw + i] !== {4'(i), pay[i]}) begin bad++; $display("FAIL mid_write%0d: got %h want %h", i, wlog[bw + i], {4'(i), pay[i]}); end
        end
        total++; if (done_cnt - bd != 1 || Zero !== 1'b0) begin bad++; $display("FAIL mid_done: done %0d zero %b want 1 0", done_cnt - bd, Zero); end
    endtask

`ifdef L2_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int bd, be;
        bd = done_cnt; be = err_cnt;
        for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
        put_byte(8'hA5);
        for (int i = 0; i < 3; i++) put_byte(pay[i]);
        idle(TO + 2);
        total++; if (err_cnt - be != 1) begin bad++; $display("FAIL to_err: got %0d want 1", err_cnt - be); end
        total++; if ({Zero, busy} !== 2'b10) begin bad++; $display("FAIL to_state: zero/busy got %b want 10", {Zero, busy}); end
        send_frame(8'((256 - (pay_sum() % 256)) % 256), 0);
        idle(2);
        total++; if (done_cnt - bd != 1 || splice_vec() !== pay_vec()) begin bad++; $display("FAIL to_recover: done %0d splice %h want %h", done_cnt - bd, splice_vec(), pay_vec()); end
    endtask
`else
    task automatic test_timeout();
        int bd, be;
        bd = done_cnt; be = err_cnt;
        for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
        put_byte(8'hA5);
        for (int i = 0; i < 3; i++) put_byte(pay[i]);
        idle(TO + 80);
        total++; if (err_cnt - be != 0 || busy !== 1'b1) begin bad++; $display("FAIL long_idle: err %0d busy %b want 0 1", err_cnt - be, busy); end
        for (int i = 3; i < NB; i++) put_byte(pay[i]);
        put_byte(8'((256 - (pay_sum() % 256)) % 256));
        idle(2);
        total++; if (done_cnt - bd != 1 || splice_vec() !== pay_vec()) begin bad++; $display("FAIL long_idle_done: done %0d splice %h want %h", done_cnt - bd, splice_vec(), pay_vec()); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_random_frames(20);
        test_back_to_back();
        test_reset_midframe();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
